// File: rtl/reg_xfer_if.sv
// reg_xfer_if
// Command and control-bus bundle between the instruction decoder and the
// register-transfer sequencer.
//   cmd_valid/cmd_ready  command handshake (decoder -> sequencer)
//   cmd_op               0 = MOV (src -> dst over data bus), 1 = ALU (dst <- alu_result)
//   cmd_src/cmd_dst      register codes 0..7 = A, B, C, D, M1, M2, X, Y
//   sel/ld               one-hot bus select and load strobes to the register unit
//   busy/done/err        sequencer status; done and err are one-cycle pulses
// master: decoder side. slave: sequencer side.
interface reg_xfer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_op;
    logic [2:0] cmd_src;
    logic [2:0] cmd_dst;
    logic [7:0] sel;
    logic [7:0] ld;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output cmd_valid, cmd_op, cmd_src, cmd_dst,
        input  cmd_ready, sel, ld, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_src, cmd_dst,
        output cmd_ready, sel, ld, busy, done, err
    );
endinterface

// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl
// Sequencer for the register unit. Takes one transfer command at a time and
// drives the per-register bus select and load strobes with relay-safe timing:
// select is asserted alone for SETTLE_CYCLES before the load strobe and held
// alone for SETTLE_CYCLES after it, so relays make before load and break after.
//   MOV src!=dst : SEL(S) -> LOAD(L) -> HOLD(S) -> DONE
//   MOV src==dst : DONE (no strobes)
//   ALU          : LOAD(L, no select) -> DONE
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any command in flight
//   bus    reg_xfer_if.slave (cmd_* in; cmd_ready, sel, ld, busy, done, err out)
// Parameters:
//   SETTLE_CYCLES  select-alone cycles before and after the load (1..15)
//   LOAD_CYCLES    load strobe length in cycles (1..15)
// Build option:
//   REG_XFER_DST_CHECK_EN  when defined, ALU commands whose destination is not
//   A or D are accepted but not executed: done and err pulse together.
//   When undefined, err is constant 0.
// All outputs come straight from flops; no combinational path from cmd_* to sel/ld.
module reg_xfer_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOAD_CYCLES   = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    reg_xfer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_LOAD,
        S_HOLD,
        S_DONE
    } state_t;

    // The counter is loaded with N-1 on entry and the state is left when it hits 0,
    // so a state lasts exactly N cycles.
    localparam logic [3:0] SETTLE_RLD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LOAD_RLD   = 4'(LOAD_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic [7:0] sel_r;
    logic [7:0] ld_r;
    logic       busy_r;
    logic       done_r;
    logic       err_r;
    logic       ready_r;

    // Captured command fields (no reset needed: only read after an accept).
    logic       op_r;
    logic [2:0] dst_r;

    function automatic logic [7:0] onehot(input logic [2:0] code);
        onehot = 8'b1 << code;
    endfunction

    always_ff @(posedge clk) begin
        if (state == S_IDLE && bus.cmd_valid) begin
            op_r  <= bus.cmd_op;
            dst_r <= bus.cmd_dst;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            sel_r   <= 8'h00;
            ld_r    <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // cmd_ready is high exactly in IDLE, so valid alone completes the handshake.
                    if (bus.cmd_valid) begin
                        busy_r  <= 1'b1;
                        ready_r <= 1'b0;
                        if (bus.cmd_op) begin
`ifdef REG_XFER_DST_CHECK_EN
                            if (bus.cmd_dst != 3'd0 && bus.cmd_dst != 3'd3) begin
                                state  <= S_DONE;
                                cnt    <= 4'd0;
                                done_r <= 1'b1;
                                err_r  <= 1'b1;
                            end else
`endif
                            begin
                                state <= S_LOAD;
                                cnt   <= LOAD_RLD;
                                ld_r  <= onehot(bus.cmd_dst);
                            end
                        end else if (bus.cmd_src == bus.cmd_dst) begin
                            // Register copied onto itself: nothing to move.
                            state  <= S_DONE;
                            cnt    <= 4'd0;
                            done_r <= 1'b1;
                        end else begin
                            state <= S_SEL;
                            cnt   <= SETTLE_RLD;
                            sel_r <= onehot(bus.cmd_src);
                        end
                    end
                end

                S_SEL: begin
                    if (cnt == 4'd0) begin
                        state <= S_LOAD;
                        cnt   <= LOAD_RLD;
                        ld_r  <= onehot(dst_r);
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_LOAD: begin
                    if (cnt == 4'd0) begin
                        ld_r <= 8'h00;
                        if (op_r) begin
                            state  <= S_DONE;
                            cnt    <= 4'd0;
                            done_r <= 1'b1;
                        end else begin
                            // Select stays on through HOLD so the load relay opens first.
                            state <= S_HOLD;
                            cnt   <= SETTLE_RLD;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_HOLD: begin
                    if (cnt == 4'd0) begin
                        state  <= S_DONE;
                        cnt    <= 4'd0;
                        sel_r  <= 8'h00;
                        done_r <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                S_DONE: begin
                    state   <= S_IDLE;
                    cnt     <= 4'd0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end

                default: begin
                    state   <= S_IDLE;
                    cnt     <= 4'd0;
                    sel_r   <= 8'h00;
                    ld_r    <= 8'h00;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ready_r;
    assign bus.sel       = sel_r;
    assign bus.ld        = ld_r;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
Sequencer for the register unit. It accepts one transfer command at a time and drives the per-register select (bus output enable) and load strobes with relay-safe timing. MOV commands copy a source register to a destination register over the shared data bus. ALU commands load a destination from the ALU result with no bus select. It sits between the instruction decoder and the register unit's control bus (ldX/selX lines).

Parameters:
SETTLE_CYCLES, 2, cycles select is held alone before load and after load (bus settle / relay break); legal range 1..15
LOAD_CYCLES, 3, cycles the load strobe is held; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command (IDLE only)
cmd_op  input  1  0=MOV (src->dst via data bus), 1=ALU (dst<-alu_result)
cmd_src  input  3  source register code; ignored for ALU
cmd_dst  input  3  destination register code
sel  output  8  one-hot bus select, bit index = register code
ld  output  8  one-hot load strobe, bit index = register code
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a command completes
err  output  1  one-cycle pulse on a rejected command (see Optional Feature)

Behaviour:
- Register codes: 0=A, 1=B, 2=C, 3=D, 4=M1, 5=M2, 6=X, 7=Y.
- Reset (async assert, sync-safe deassert): state IDLE, counter 0, sel=0, ld=0, busy=0, done=0, err=0, cmd_ready=1 after deassert. Reset mid-command aborts it immediately; the command is discarded and strobes drop in the same instant.
- Handshake: accept when cmd_valid && cmd_ready at a rising edge. src, dst and op are captured into internal registers. Inputs are ignored while busy. cmd_ready=1 in IDLE only, so the next accept can occur at the earliest in the cycle after done.
- States: IDLE, SEL, LOAD, HOLD, DONE. One down-counter of 4 bits is reloaded on each state entry.
- MOV, src!=dst: IDLE -> SEL for SETTLE_CYCLES (sel[src]=1, ld=0) -> LOAD for LOAD_CYCLES (sel[src]=1, ld[dst]=1) -> HOLD for SETTLE_CYCLES (sel[src]=1, ld=0) -> DONE for 1 cycle (sel=0, ld=0, done=1) -> IDLE.
- MOV, src==dst: no-op. IDLE -> DONE -> IDLE. No sel or ld is ever asserted.
- ALU: IDLE -> LOAD for LOAD_CYCLES (ld[dst]=1, sel=0) -> DONE -> IDLE. SEL and HOLD are skipped.
- Latency, accept edge to first DONE cycle: MOV = 2*SETTLE_CYCLES+LOAD_CYCLES+1 cycles; ALU = LOAD_CYCLES+1; no-op MOV = 1.
- Invariants, checked by assertions:
  - sel and ld are each zero or one-hot.
  - ld[k] is never high unless sel has been stable for at least SETTLE_CYCLES (MOV).
  - sel never changes while ld != 0.
  - No ld and sel on the same bit simultaneously.
- All outputs are registered; no combinational path from cmd_* to sel/ld.

Optional Feature:
Macro: REG_XFER_DST_CHECK_EN.
- Defined: an ALU command whose dst is not A(0) or D(3) is accepted (handshake completes) but not executed. IDLE -> DONE with err=1 and done=1 in the same cycle, no ld. A MOV with dst=M1/M2/X/Y stays legal.
- Undefined: no check. Every ALU dst executes normally; err is tied 0.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> sel=0, ld=0, busy=0, done=0, cmd_ready=1. Assert rst_n low async mid-LOAD -> ld and sel drop before the next edge; after release the controller is IDLE.
- MOV B->C (defaults S=2, L=3): sel=0x02 for 7 cycles (accept+1 .. accept+7), ld=0x04 on cycles accept+3..accept+5, done pulse at accept+8, cmd_ready back at accept+9.
- ALU dst=D: ld=0x08 for 3 cycles starting accept+1, sel stays 0x00, done at accept+4.
- MOV A->A: no strobes, done at accept+1. Back-to-back commands: cmd_valid held high with a second command waiting -> second accept occurs exactly one cycle after done, never earlier.
- With REG_XFER_DST_CHECK_EN: ALU dst=X(6) -> err=1 and done=1 at accept+1, ld stays 0. Without the macro: ld=0x40 for 3 cycles, err stays 0.
- Parameter sweep SETTLE_CYCLES=1, LOAD_CYCLES=1: MOV Y->M1 -> sel=0x80 for 3 cycles, ld=0x10 for 1 cycle in the middle, done at accept+4. Invariant assertions hold for the whole run.
